// File: rtl/uni_axil_bridge_if.sv
// Request port between the core's LSU/IFU master and the bus-side slave.
// One request is held on valid until the slave returns a one-cycle ready pulse.
interface uni_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              reqtyp;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              cachable;
    logic [1:0]        size;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport Master (output valid, reqtyp, addr, wdata, cachable, size, input ready, rdata);
    modport Slave  (input valid, reqtyp, addr, wdata, cachable, size, output ready, rdata);
endinterface

// File: rtl/uni_axil_bridge.sv
// Converts one uni_if request at a time into a single AXI4-Lite master transaction.
// Misaligned requests are answered locally with bus_err and never reach the bus.
module uni_axil_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    uni_if.Slave              up,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    output logic [DATA_W-1:0] axi_wdata,
    output logic [3:0]        axi_wstrb,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    input  logic [1:0]        axi_bresp,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [ADDR_W-1:0] axi_araddr,
    input  logic              axi_rvalid,
    output logic              axi_rready,
    input  logic [DATA_W-1:0] axi_rdata,
    input  logic [1:0]        axi_rresp,
    output logic              bus_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_A  = 3'd1;
    localparam logic [2:0] RD_R  = 3'd2;
    localparam logic [2:0] WR_AW = 3'd3;
    localparam logic [2:0] WR_B  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic              misal_q;
    logic              ready_r;
    logic [DATA_W-1:0] rdata_r;

    logic              is_half;
    logic              is_word;
    logic              misal;
    logic [DATA_W-1:0] wdata_rep;
    logic [3:0]        wstrb_dec;
    logic              aw_left;
    logic              w_left;

    // Size 2'b11 is decoded as a word; narrow write data is replicated across all lanes.
    always_comb begin
        is_half = (up.size == 2'b01);
        is_word = up.size[1];
        misal   = (is_half && up.addr[0]) || (is_word && (up.addr[1:0] != 2'b00));
        if (is_word) begin
            wdata_rep = up.wdata;
            wstrb_dec = 4'hF;
        end else if (is_half) begin
            wdata_rep = {2{up.wdata[15:0]}};
            wstrb_dec = 4'b0011 << {up.addr[1], 1'b0};
        end else begin
            wdata_rep = {4{up.wdata[7:0]}};
            wstrb_dec = 4'b0001 << up.addr[1:0];
        end
    end

    assign aw_left = axi_awvalid && !axi_awready;
    assign w_left  = axi_wvalid && !axi_wready;

    assign axi_awaddr = addr_q;
    assign axi_araddr = addr_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign up.ready   = ready_r;
    assign up.rdata   = rdata_r;

    // The ready pulse lands while back in IDLE, so a still-held valid is ignored in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= 2'b00;
            misal_q     <= 1'b0;
            ready_r     <= 1'b0;
            rdata_r     <= '0;
            bus_err     <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
        end else begin
            ready_r <= 1'b0;
            rdata_r <= '0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (up.valid && !ready_r) begin
                        addr_q  <= up.addr;
                        wdata_q <= wdata_rep;
                        wstrb_q <= wstrb_dec;
                        misal_q <= misal;
                        resp_q  <= 2'b00;
                        rdata_q <= '0;
                        if (misal) begin
                            state <= DONE;
                        end else if (!up.reqtyp) begin
                            state       <= RD_A;
                            axi_arvalid <= 1'b1;
                        end else begin
                            state       <= WR_AW;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= RD_R;
                    end
                end
                RD_R: begin
                    if (axi_rvalid) begin
                        rdata_q    <= axi_rdata;
                        resp_q     <= axi_rresp;
                        axi_rready <= 1'b0;
                        state      <= DONE;
                    end
                end
                WR_AW: begin
                    if (axi_awready) axi_awvalid <= 1'b0;
                    if (axi_wready)  axi_wvalid  <= 1'b0;
                    if (!aw_left && !w_left) begin
                        axi_bready <= 1'b1;
                        state      <= WR_B;
                    end
                end
                WR_B: begin
                    if (axi_bvalid) begin
                        resp_q     <= axi_bresp;
                        axi_bready <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    ready_r <= 1'b1;
                    rdata_r <= rdata_q;
                    bus_err <= misal_q || (resp_q != 2'b00);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
